// File: rtl/support_mem_arbiter.sv
// support_mem_arbiter
//   Two bus channels share one synchronous RAM of 2**AW x DW words.
//   ch0 is the supervisor CPU; ch1 is a secondary master (DMA/loader).
//   Each channel gets a wait-state handshake. Read latency is configurable
//   (RD_LAT edges). Arbitration is fixed priority or round-robin (RR_ARB).
//
// Handshake: a master raises cN_rd or cN_wr, which is a level request. If both
//   are high, the operation is a write. The master holds cN_A, cN_Din and the
//   request stable while cN_wait is high. In the first cycle where cN_wait is
//   low, the transaction is complete. For reads, cN_Dout is valid in that
//   cycle and is held until the next read for that channel. If the request is
//   still high when the FSM returns to IDLE, it starts a new transaction.
//
// Ports
//   clk, reset     clock; asynchronous active-high reset
//   cN_A           channel N address (AW bits)
//   cN_Din         channel N write data (DW bits)
//   cN_Dout        channel N read data, registered and held
//   cN_rd, cN_wr   channel N read / write request levels
//   cN_wait        channel N stall, high while its request is not complete
//   fsm_state      debug view of the FSM state (0 IDLE, 1 BUSY, 2 DONE)
module support_mem_arbiter #(
   parameter int AW     = 16,
   parameter int DW     = 8,
   parameter int RD_LAT = 1,
   parameter int RR_ARB = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] c0_A,
   input  logic [DW-1:0] c0_Din,
   output logic [DW-1:0] c0_Dout,
   input  logic          c0_rd,
   input  logic          c0_wr,
   output logic          c0_wait,
   input  logic [AW-1:0] c1_A,
   input  logic [DW-1:0] c1_Din,
   output logic [DW-1:0] c1_Dout,
   input  logic          c1_rd,
   input  logic          c1_wr,
   output logic          c1_wait,
   output logic [1:0]    fsm_state
);

   generate
      if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
         $error("support_mem_arbiter: RD_LAT must be in 1..4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);
   localparam bit         RR_MODE  = (RR_ARB != 0);

   logic [DW-1:0] mem [0:(2**AW)-1];

   state_t        state;
   logic          gnt;     // granted channel: 0 = ch0, 1 = ch1
   logic          last;    // last granted channel, used for round-robin
   logic          op_wr;
   logic [AW-1:0] a_q;
   logic [DW-1:0] din_q;
   logic [1:0]    cnt;
   logic          done0;
   logic          done1;
   logic          req0;
   logic          req1;
   logic          pick1;

   assign req0 = c0_rd | c0_wr;
   assign req1 = c1_rd | c1_wr;

   // ch1 wins if it is the only requester. In round-robin mode, it also wins
   // when ch0 was the last channel granted.
   assign pick1 = req1 & (~req0 | (RR_MODE & ~last));

   assign c0_wait   = req0 & ~done0;
   assign c1_wait   = req1 & ~done1;
   assign fsm_state = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         gnt     <= 1'b0;
         last    <= 1'b1;   // points at ch1 so ch0 is granted first
         op_wr   <= 1'b0;
         a_q     <= '0;
         din_q   <= '0;
         cnt     <= 2'd0;
         done0   <= 1'b0;
         done1   <= 1'b0;
         c0_Dout <= '0;
         c1_Dout <= '0;
      end else begin
         done0 <= 1'b0;
         done1 <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 | req1) begin
                  gnt   <= pick1;
                  last  <= pick1;
                  op_wr <= pick1 ? c1_wr  : c0_wr;
                  a_q   <= pick1 ? c1_A   : c0_A;
                  din_q <= pick1 ? c1_Din : c0_Din;
                  cnt   <= 2'd0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (op_wr) begin
                  // The RAM write itself happens in the memory block on this edge.
                  state <= DONE;
                  done0 <= ~gnt;
                  done1 <= gnt;
               end else if (cnt == CNT_LAST) begin
                  if (gnt) c1_Dout <= mem[a_q];
                  else     c0_Dout <= mem[a_q];
                  state <= DONE;
                  done0 <= ~gnt;
                  done1 <= gnt;
               end else begin
                  cnt <= cnt + 2'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // The RAM has no reset. An async reset during BUSY moves the state out of
   // BUSY before the committing edge, so a partial write cannot occur.
   always_ff @(posedge clk) begin
      if (state == BUSY && op_wr) mem[a_q] <= din_q;
   end

endmodule

// File: tb/tb_support_mem_arbiter.sv
// Testbench for support_mem_arbiter. It drives three instances:
//   inst 0: RD_LAT=1, fixed priority
//   inst 1: RD_LAT=1, round-robin
//   inst 2: RD_LAT=4, fixed priority
// Entry format in exp_q: {is_read, data[7:0], wait_cycles[3:0]}.
module tb_support_mem_arbiter;

   localparam int W = 13;

   logic        clk;
   logic        rst;
   logic [15:0] a    [3][2];
   logic [7:0]  din  [3][2];
   logic [7:0]  dout [3][2];
   logic        rd   [3][2];
   logic        wr   [3][2];
   logic        wt   [3][2];
   logic [1:0]  st   [3];

   logic [W-1:0] exp_q [6][$];
   logic [W-1:0] mon_e;
   int           wcnt  [6];
   int           n_checks;
   int           n_fail;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      support_mem_arbiter #(
         .AW(16), .DW(8),
         .RD_LAT(g == 2 ? 4 : 1),
         .RR_ARB(g == 1 ? 1 : 0)
      ) dut (
         .clk(clk), .reset(rst),
         .c0_A(a[g][0]), .c0_Din(din[g][0]), .c0_Dout(dout[g][0]),
         .c0_rd(rd[g][0]), .c0_wr(wr[g][0]), .c0_wait(wt[g][0]),
         .c1_A(a[g][1]), .c1_Din(din[g][1]), .c1_Dout(dout[g][1]),
         .c1_rd(rd[g][1]), .c1_wr(wr[g][1]), .c1_wait(wt[g][1]),
         .fsm_state(st[g])
      );
   end

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   // driver: call with time just after a rising edge; returns just after a rising edge
   task automatic issue(input int i, input int c, input bit w, input logic [15:0] ad,
                        input logic [7:0] d, input int lat);
      bit seen;
      exp_q[i*2+c].push_back({~w, d, 4'(lat)});
      a[i][c]   = ad;
      din[i][c] = w ? d : 8'h00;
      wr[i][c]  = w;
      rd[i][c]  = ~w;
      seen = 1'b0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (!wt[i][c]) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout inst%0d ch%0d: wait still %b expected 0", i, c, wt[i][c]);
      end
      @(posedge clk);
      #1;
      rd[i][c] = 1'b0;
      wr[i][c] = 1'b0;
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rst) begin
         for (int k = 0; k < 6; k++) wcnt[k] = 0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 2; c++) begin
               if (rd[i][c] | wr[i][c]) begin
                  if (wt[i][c]) begin
                     wcnt[i*2+c]++;
                  end else begin
                     if (exp_q[i*2+c].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_done inst%0d ch%0d: got completion expected none", i, c);
                     end else begin
                        mon_e = exp_q[i*2+c].pop_front();
                        n_checks++;
                        if (wcnt[i*2+c] != int'(mon_e[3:0])) begin
                           n_fail++;
                           $display("FAIL wait_cycles inst%0d ch%0d: got %0d expected %0d",
                                    i, c, wcnt[i*2+c], mon_e[3:0]);
                        end
                        if (mon_e[12]) begin
                           n_checks++;
                           if (dout[i][c] !== mon_e[11:4]) begin
                              n_fail++;
                              $display("FAIL read_data inst%0d ch%0d: got %h expected %h",
                                       i, c, dout[i][c], mon_e[11:4]);
                           end
                        end
                     end
                     wcnt[i*2+c] = 0;
                  end
               end else begin
                  wcnt[i*2+c] = 0;
               end
            end
         end
      end
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      for (int i = 0; i < 3; i++) begin
         for (int c = 0; c < 2; c++) begin
            a[i][c] = '0; din[i][c] = '0; rd[i][c] = 1'b0; wr[i][c] = 1'b0;
         end
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset_state%0d", i), 16'(st[i]), 16'h0);
         for (int c = 0; c < 2; c++) chk($sformatf("reset_dout%0d_%0d", i, c), 16'(dout[i][c]), 16'h0);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 1: ch0 write, Dout untouched
      issue(0, 0, 1'b1, 16'h1234, 8'hA5, 2);
      chk("t1_c0_dout", 16'(dout[0][0]), 16'h0);
      chk("t1_c1_dout", 16'(dout[0][1]), 16'h0);

      // 2: ch0 read back, held after request drops
      issue(0, 0, 1'b0, 16'h1234, 8'hA5, 2);
      repeat (2) @(negedge clk);
      chk("t2_dout_held", 16'(dout[0][0]), 16'hA5);
      @(posedge clk);
      #1;

      // 3: fixed priority, simultaneous reads; ch1 waits one full transaction
      issue(0, 1, 1'b1, 16'h0500, 8'h5A, 2);
      fork
         issue(0, 0, 1'b0, 16'h1234, 8'hA5, 2);
         issue(0, 1, 1'b0, 16'h0500, 8'h5A, 5);
      join

      // 4: round-robin, both masters streaming reads
      issue(1, 0, 1'b1, 16'h0001, 8'h11, 2);
      issue(1, 0, 1'b1, 16'h0002, 8'h22, 2);
      issue(1, 1, 1'b1, 16'h0003, 8'h33, 2);
      issue(1, 1, 1'b1, 16'h0004, 8'h44, 2);
      fork
         begin
            issue(1, 0, 1'b0, 16'h0001, 8'h11, 2);
            issue(1, 0, 1'b0, 16'h0002, 8'h22, 5);
         end
         begin
            issue(1, 1, 1'b0, 16'h0003, 8'h33, 5);
            issue(1, 1, 1'b0, 16'h0004, 8'h44, 5);
         end
      join

      // 5: RD_LAT=4, ch1 reads data ch0 just wrote
      issue(2, 0, 1'b1, 16'h0200, 8'h77, 2);
      issue(2, 0, 1'b0, 16'h0200, 8'h77, 5);
      issue(2, 0, 1'b1, 16'h0100, 8'h3C, 2);
      issue(2, 1, 1'b0, 16'h0100, 8'h3C, 5);
      chk("t5_c0_dout_unchanged", 16'(dout[2][0]), 16'h77);

      // 6: reset in the BUSY cycle of a write
      issue(0, 0, 1'b1, 16'h0010, 8'h00, 2);
      a[0][0]   = 16'h0010;
      din[0][0] = 8'h55;
      wr[0][0]  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("t6_busy_before_reset", 16'(st[0]), 16'h1);
      rst = 1'b1;
      #1;
      chk("t6_state_idle", 16'(st[0]), 16'h0);
      for (int i = 0; i < 3; i++) begin
         for (int c = 0; c < 2; c++) chk($sformatf("t6_dout%0d_%0d", i, c), 16'(dout[i][c]), 16'h0);
      end
      wr[0][0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      issue(0, 0, 1'b0, 16'h0010, 8'h00, 2);

      repeat (3) @(posedge clk);
      for (int k = 0; k < 6; k++) chk($sformatf("queue_empty%0d", k), 16'(exp_q[k].size()), 16'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
